mcpu_ps2_keyboard: RTL and testbench
====================================

Name: mcpu_ps2_keyboard

Overview:
PS/2 keyboard receiver that feeds the top-level 8-bit keycode input, which the core reads as ALU Y. It deserialises 11-bit PS/2 device-to-host frames and checks start, parity and stop bits. It folds the E0 (extended) and F0 (break) prefixes into flags and queues decoded keys in a small show-ahead FIFO. The CPU consumes one entry per key_pop.

Parameters:
FIFO_AW, 2, log2 of FIFO depth (default 4 entries)
TIMEOUT, 4000, clk cycles without a PS/2 falling edge before a partial frame is abandoned

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock line, asynchronous
ps2_data  input  1  raw PS/2 data line, asynchronous
key_pop  input  1  consume head entry
keycode  output  8  head scancode; 0 when FIFO empty
key_release  output  1  head entry was preceded by F0
key_ext  output  1  head entry was preceded by E0
key_valid  output  1  FIFO non-empty
fifo_count  output  FIFO_AW+1  number of queued entries
frame_err  output  1  one-cycle pulse on a bad or timed-out frame
overflow  output  1  one-cycle pulse when a decoded key is dropped because the FIFO is full

Behaviour:
- Reset (reset=0, async):
  - Sync flops = 1.
  - FSM = IDLE; bit counter, shift register and timeout counter = 0.
  - Both pending flags clear; FIFO empty.
  - All outputs 0.
  - Reset mid-frame discards the partial frame.
- Input sync and edge detect:
  - 2-flop synchroniser on each of ps2_clk and ps2_data.
  - fall = prev_synced_clk & ~synced_clk.
  - All sampling uses synced ps2_data in the fall cycle.
- FSM (advances only on fall):
  - IDLE: data=0 -> DATA with bitcnt=0; data=1 -> stay in IDLE.
  - DATA: shift LSB-first; after the 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: good iff data=1 and XOR(8 data bits, parity)=1 (odd parity). Good -> process byte; bad -> frame_err pulse. Either way -> IDLE.
- Timeout:
  - Counter clears on every fall and in IDLE; increments otherwise, saturating.
  - Outside IDLE, reaching TIMEOUT-1 -> IDLE plus a frame_err pulse.
- Byte processing (same cycle as the good STOP fall):
  - 0xE0: set ext_pending; no push.
  - 0xF0: set rel_pending; no push.
  - Any other byte: push {rel_pending, ext_pending, byte}, then clear both pending flags.
  - Any frame_err also clears both pending flags.
- FIFO:
  - 2^FIFO_AW entries x 10 bits, circular read/write pointers.
  - Show-ahead: keycode, key_release and key_ext show the head entry combinationally from registered storage; all three read 0 when empty.
  - Push latency: key_valid and fifo_count update on the clock edge after the STOP fall cycle.
  - Pop: key_pop & key_valid advances the head at the clock edge. key_pop while empty is ignored.
  - Push while full: byte dropped, contents unchanged, overflow pulses for 1 cycle.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: pop ignored, push occurs.
  - Pointers wrap modulo 2^FIFO_AW.

Test Plan:
1. Send frame 0x1C: start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1 -> one cycle after the stop fall: key_valid=1, keycode=0x1C, key_release=0, key_ext=0, fifo_count=1.
2. Send F0 then 1C -> exactly one entry: keycode=0x1C, key_release=1, key_ext=0, fifo_count=1. Then E0, F0, 75 -> second entry keycode=0x75, key_release=1, key_ext=1.
3. Send 0x1C with parity=1 -> frame_err pulses 1 cycle, fifo_count stays 0. Repeat with stop=0 -> same result. Send F0 then a bad frame then 0x1C -> entry has key_release=0.
4. Send start + 3 data bits, then hold ps2_clk high for TIMEOUT cycles -> frame_err pulse, FSM in IDLE. A following clean 0x29 frame is received as keycode=0x29.
5. Push 0x16,0x1E,0x26,0x25,0x2E with no pops -> fifo_count=4, overflow pulses on the 5th, head=0x16. Then pop 4 times -> 0x16,0x1E,0x26,0x25 in order, then key_valid=0, keycode=0. One extra pop -> no change.
6. With the FIFO full, assert key_pop in the same cycle as a new push -> count stays 4, no overflow. Separately, assert reset=0 mid-frame and mid-FIFO -> all outputs 0 immediately (async); the next clean frame decodes correctly.

Source files
------------

// File: rtl/mcpu_ps2_keyboard_if.sv
// Key FIFO side of the PS/2 keyboard receiver.
// The CPU consumes the head entry with key_pop.
`timescale 1ns/1ps
interface mcpu_ps2_keyboard_if #(
  parameter int FIFO_AW = 2
);
  logic             key_pop;
  logic [7:0]       keycode;
  logic             key_release;
  logic             key_ext;
  logic             key_valid;
  logic [FIFO_AW:0] fifo_count;
  logic             frame_err;
  logic             overflow;

  modport master (
    input  key_pop,
    output keycode,
    output key_release,
    output key_ext,
    output key_valid,
    output fifo_count,
    output frame_err,
    output overflow
  );

  modport slave (
    output key_pop,
    input  keycode,
    input  key_release,
    input  key_ext,
    input  key_valid,
    input  fifo_count,
    input  frame_err,
    input  overflow
  );
endinterface

// File: rtl/mcpu_ps2_keyboard.sv
// PS/2 device-to-host receiver with E0/F0 prefix folding
// and a show-ahead key FIFO feeding the core's keycode input.
`timescale 1ns/1ps
module mcpu_ps2_keyboard #(
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 4000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  mcpu_ps2_keyboard_if.master kb
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  state_t state, state_n;

  logic c_s1, c_s2, c_prev;
  logic d_s1, d_s2;
  logic fall;

  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          ext_p, ext_p_n;
  logic          rel_p, rel_p_n;
  logic          push, bad;
  logic          good;

  logic [9:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0] count;
  logic             empty, full;
  logic             do_pop, do_push, drop;
  logic             err_q, ovf_q;
  logic [9:0]       head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_s1   <= 1'b1;
      c_s2   <= 1'b1;
      c_prev <= 1'b1;
      d_s1   <= 1'b1;
      d_s2   <= 1'b1;
    end else begin
      c_s1   <= ps2_clk;
      c_s2   <= c_s1;
      c_prev <= c_s2;
      d_s1   <= ps2_data;
      d_s2   <= d_s1;
    end
  end

  assign fall = c_prev & ~c_s2;
  assign good = d_s2 & (^{shreg, par});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tcnt   <= '0;
      ext_p  <= 1'b0;
      rel_p  <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      par    <= par_n;
      tcnt   <= tcnt_n;
      ext_p  <= ext_p_n;
      rel_p  <= rel_p_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    ext_p_n  = ext_p;
    rel_p_n  = rel_p;
    push     = 1'b0;
    bad      = 1'b0;
    if (fall || state == IDLE)
      tcnt_n = '0;
    else if (tcnt == '1)
      tcnt_n = tcnt;
    else
      tcnt_n = tcnt + 1'b1;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!d_s2) begin
            state_n  = DATA;
            bitcnt_n = '0;
          end
        end
        DATA: begin
          shreg_n  = {d_s2, shreg[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7)
            state_n = PARITY;
        end
        PARITY: begin
          par_n   = d_s2;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          unique case (1'b1)
            !good: begin
              bad     = 1'b1;
              ext_p_n = 1'b0;
              rel_p_n = 1'b0;
            end
            shreg == 8'hE0: ext_p_n = 1'b1;
            shreg == 8'hF0: rel_p_n = 1'b1;
            default: begin
              push    = 1'b1;
              ext_p_n = 1'b0;
              rel_p_n = 1'b0;
            end
          endcase
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TO_LAST) begin
      // stalled partial frame: abandon it
      state_n = IDLE;
      bad     = 1'b1;
      ext_p_n = 1'b0;
      rel_p_n = 1'b0;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = kb.key_pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= {rel_p, ext_p, shreg};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      err_q <= bad;
      ovf_q <= drop;
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  assign head           = empty ? '0 : mem[rptr];
  assign kb.keycode     = head[7:0];
  assign kb.key_ext     = head[8];
  assign kb.key_release = head[9];
  assign kb.key_valid   = ~empty;
  assign kb.fifo_count  = count;
  assign kb.frame_err   = err_q;
  assign kb.overflow    = ovf_q;
endmodule

// File: tb/tb_mcpu_ps2_keyboard.sv
// Bench for mcpu_ps2_keyboard: frame table plus hand sequences
// for timeout, full-FIFO push/pop and async reset.
`timescale 1ns/1ps
module tb_mcpu_ps2_keyboard;
  localparam int AW   = 2;
  localparam int TO   = 200;
  localparam int HALF = 20;
  localparam int DEP  = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  mcpu_ps2_keyboard_if #(.FIFO_AW(AW)) kb ();

  mcpu_ps2_keyboard #(
    .FIFO_AW(AW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .kb(kb.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         bp;
    bit         bs;
    int         cnt;
    int         err;
    int         ov;
    bit         drain;
  } vec_t;

  vec_t       vt[$];
  logic [9:0] sb[$];
  bit         m_ext, m_rel;
  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int ov_cnt = 0;

  always @(negedge clk) begin
    if (kb.frame_err) err_cnt++;
    if (kb.overflow) ov_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b, input bit pop_sync);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_sync) begin
      // pop lands on the same edge as the push
      repeat (2) @(negedge clk);
      kb.key_pop = 1'b1;
      @(negedge clk);
      kb.key_pop = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bp,
                      input bit bs, input bit pop_sync);
    logic [10:0] f;
    f = {~bs, (~^b) ^ bp, b, 1'b0};
    for (int i = 0; i < 11; i++)
      ps2_bit(f[i], pop_sync && i == 10);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    if (bp || bs) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      if (pop_sync) void'(sb.pop_front());
      if (sb.size() < DEP) sb.push_back({m_rel, m_ext, b});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic check_head();
    chk("key_valid", kb.key_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("keycode", kb.keycode, sb[0][7:0]);
      chk("key_ext", kb.key_ext, sb[0][8]);
      chk("key_release", kb.key_release, sb[0][9]);
    end else begin
      chk("keycode_empty", kb.keycode, 0);
    end
  endtask

  task automatic pop();
    kb.key_pop = 1'b1;
    @(negedge clk);
    kb.key_pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    while (sb.size() != 0) begin
      check_head();
      pop();
      void'(sb.pop_front());
    end
    chk("drain_valid", kb.key_valid, 0);
    chk("drain_code", kb.keycode, 0);
    chk("drain_count", kb.fifo_count, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_code"}, kb.keycode, 0);
    chk({nm, "_rel"}, kb.key_release, 0);
    chk({nm, "_ext"}, kb.key_ext, 0);
    chk({nm, "_valid"}, kb.key_valid, 0);
    chk({nm, "_count"}, kb.fifo_count, 0);
    chk({nm, "_err"}, kb.frame_err, 0);
    chk({nm, "_ovf"}, kb.overflow, 0);
  endtask

  initial begin
    int e0, o0;
    kb.key_pop = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;

    vt.push_back('{8'h1C, 0, 0, 1, 0, 0, 1});
    vt.push_back('{8'hF0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{8'h1C, 0, 0, 1, 0, 0, 0});
    vt.push_back('{8'hE0, 0, 0, 1, 0, 0, 0});
    vt.push_back('{8'hF0, 0, 0, 1, 0, 0, 0});
    vt.push_back('{8'h75, 0, 0, 2, 0, 0, 1});
    vt.push_back('{8'h1C, 1, 0, 0, 1, 0, 0});
    vt.push_back('{8'h1C, 0, 1, 0, 1, 0, 0});
    vt.push_back('{8'hF0, 0, 0, 0, 0, 0, 0});
    vt.push_back('{8'h1C, 1, 0, 0, 1, 0, 0});
    vt.push_back('{8'h1C, 0, 0, 1, 0, 0, 1});
    vt.push_back('{8'h16, 0, 0, 1, 0, 0, 0});
    vt.push_back('{8'h1E, 0, 0, 2, 0, 0, 0});
    vt.push_back('{8'h26, 0, 0, 3, 0, 0, 0});
    vt.push_back('{8'h25, 0, 0, 4, 0, 0, 0});
    vt.push_back('{8'h2E, 0, 0, 4, 0, 1, 1});

    repeat (5) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vt[i]) begin
      e0 = err_cnt;
      o0 = ov_cnt;
      send(vt[i].b, vt[i].bp, vt[i].bs, 1'b0);
      chk("fifo_count", kb.fifo_count, vt[i].cnt);
      chk("frame_err", err_cnt - e0, vt[i].err);
      chk("overflow", ov_cnt - o0, vt[i].ov);
      check_head();
      if (vt[i].drain) drain();
    end

    pop();
    chk("extra_pop_count", kb.fifo_count, 0);
    chk("extra_pop_valid", kb.key_valid, 0);

    e0 = err_cnt;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    chk("no_early_timeout", err_cnt - e0, 0);
    repeat (TO + 10) @(negedge clk);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_count", kb.fifo_count, 0);
    send(8'h29, 0, 0, 0);
    chk("after_to_count", kb.fifo_count, 1);
    chk("after_to_err", err_cnt - e0, 1);
    drain();

    send(8'h16, 0, 0, 0);
    send(8'h1E, 0, 0, 0);
    send(8'h26, 0, 0, 0);
    send(8'h25, 0, 0, 0);
    chk("full_count", kb.fifo_count, 4);
    o0 = ov_cnt;
    send(8'h2E, 0, 0, 1);
    chk("pushpop_count", kb.fifo_count, 4);
    chk("pushpop_ovf", ov_cnt - o0, 0);
    chk("pushpop_head", kb.keycode, 8'h1E);
    drain();

    send(8'h16, 0, 0, 0);
    send(8'h1E, 0, 0, 0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    sb.delete();
    m_ext = 1'b0;
    m_rel = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    e0 = err_cnt;
    send(8'h29, 0, 0, 0);
    chk("post_reset_count", kb.fifo_count, 1);
    chk("post_reset_err", err_cnt - e0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
